serial_code_decoder: RTL and testbench

- Receive end of the serial 2-bit code link.
- Takes an asynchronous idle-high serial line carrying framed 2-bit codes, recovers each code by mid-bit sampling and expands it to a 4-bit one-hot word.
- Presents the word on a single-entry valid/ready output buffer.
- Sits between the link pin and any consumer of one-hot selects; it is the counterpart of the transmitter that serializes 2-bit encoder outputs.

---
 rtl/serial_code_pkg.sv | 26 ++
 rtl/serial_code_decoder_bit_timer.sv | 44 ++++
 rtl/serial_code_decoder.sv | 250 +++++++++++++++++++++++++
 tb/tb_serial_code_decoder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_code_pkg.sv
// Shared definitions for the serial 2-bit code link: receiver state encoding,
// frame bit levels and the code-to-one-hot expansion. The PARITY state
// encoding only exists when SERIAL_CODE_PARITY_EN is defined.
package serial_code_pkg;

    // Receiver state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
`ifdef SERIAL_CODE_PARITY_EN
    localparam logic [2:0] ST_PARITY  = 3'd3;
`endif
    localparam logic [2:0] ST_STOP    = 3'd4;
    localparam logic [2:0] ST_WAIT_HI = 3'd5;

    // Line levels of the framing bits
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    // Expand a 2-bit code into its one-hot select word
    function automatic logic [3:0] code_to_onehot(input logic [1:0] code);
        return 4'b0001 << code;
    endfunction

endpackage

// File: rtl/serial_code_decoder_bit_timer.sv
// bit_timer: loadable down-counter that paces the serial receiver. A load
// selects a half-bit or full-bit reload; at zero it emits a one-cycle tick
// and reloads a full bit period by itself.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic half_i,
    output logic tick_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: explicit load wins, otherwise count down and wrap to a full bit
    always_comb begin
        // NOTE: assigning a default first means every path writes cnt_d, so no latch is inferred.
        cnt_d = cnt_q - CW'(1);
        if (load_i) begin
            cnt_d = half_i ? HALF_RELOAD : FULL_RELOAD;
        end else if (cnt_q == '0) begin
            cnt_d = FULL_RELOAD;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values, matching hardware.
        if (rst) begin
            cnt_q <= FULL_RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/serial_code_decoder.sv
// serial_code_decoder: receive end of the serial 2-bit code link. Recovers
// framed 2-bit codes from an asynchronous idle-high line by mid-bit sampling
// and presents the one-hot expansion on a single-entry valid/ready buffer.
// Optional feature macro: SERIAL_CODE_PARITY_EN adds an even-parity bit to
// each frame and drives parity_err; without it parity_err is tied low.
module serial_code_decoder
    import serial_code_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [3:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun
);

    // Synchronizer
    logic sync1_q;
    logic sync2_q;
    logic rx_s;

    // FSM and bit timer control
    logic [2:0] state_q;
    logic [2:0] state_d;
    logic       timer_load;
    logic       timer_half;
    logic       tick;

    // Frame capture
    logic bit_idx_q;
    logic bit_idx_d;
    logic d1_q;
    logic d1_d;
    logic d0_q;
    logic d0_d;
`ifdef SERIAL_CODE_PARITY_EN
    logic par_q;
    logic par_d;
    logic parity_err_q;
    logic parity_err_d;
`endif

    // Output buffer and status pulses
    logic [3:0] out_data_q;
    logic [3:0] out_data_d;
    logic       out_valid_q;
    logic       out_valid_d;
    logic       frame_err_q;
    logic       frame_err_d;
    logic       overrun_q;
    logic       overrun_d;

    // Two-flop synchronizer; resets to the idle level so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= IDLE_LVL;
            sync2_q <= IDLE_LVL;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (timer_load),
        .half_i (timer_half),
        .tick_o (tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: bit-level states advance only on a timer tick
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_s == START_BIT) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    // A start bit that is high again at mid-bit was a glitch
                    state_d = (rx_s == START_BIT) ? ST_DATA : ST_IDLE;
                end
            end
            ST_DATA: begin
                if (tick && !bit_idx_q) begin
`ifdef SERIAL_CODE_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef SERIAL_CODE_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    // A low stop bit may be a line break: wait for idle before re-arming
                    state_d = (rx_s != STOP_BIT) ? ST_WAIT_HI : ST_IDLE;
                end
            end
            ST_WAIT_HI: begin
                if (rx_s == IDLE_LVL) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: timer control, bit capture, stop-bit verdict and buffer update
    always_comb begin
        timer_load  = 1'b0;
        timer_half  = 1'b0;
        bit_idx_d   = bit_idx_q;
        d1_d        = d1_q;
        d0_d        = d0_q;
`ifdef SERIAL_CODE_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        // Handshake drains the buffer; a same-cycle load below overrides it
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_s == START_BIT) begin
                    timer_load = 1'b1;
                    timer_half = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    bit_idx_d = 1'b1;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx_q) begin
                        d1_d = rx_s;
                    end else begin
                        d0_d = rx_s;
                    end
                    bit_idx_d = 1'b0;
                end
            end
`ifdef SERIAL_CODE_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    par_d = rx_s;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (rx_s != STOP_BIT) begin
                        frame_err_d = 1'b1;
                    end
`ifdef SERIAL_CODE_PARITY_EN
                    else if (par_q != (d1_q ^ d0_q)) begin
                        parity_err_d = 1'b1;
                    end
`endif
                    else if (out_valid_q && !out_ready) begin
                        overrun_d = 1'b1;
                    end else begin
                        out_data_d  = code_to_onehot({d1_q, d0_q});
                        out_valid_d = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx_q    <= 1'b0;
            d1_q         <= 1'b0;
            d0_q         <= 1'b0;
`ifdef SERIAL_CODE_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
            out_data_q   <= 4'b0000;
            out_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            bit_idx_q    <= bit_idx_d;
            d1_q         <= d1_d;
            d0_q         <= d0_d;
`ifdef SERIAL_CODE_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef SERIAL_CODE_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_code_decoder.sv
// Bench for serial_code_decoder. Directed scenarios followed by random frames;
// a frame-level reference model predicts the buffer contents and status pulses
// from the frame rules and the stop-sample time, and a monitor compares every
// cycle. Honours SERIAL_CODE_PARITY_EN like the design.
`timescale 1ns/1ps
module tb_serial_code_decoder;

    localparam int N = 4;
`ifdef SERIAL_CODE_PARITY_EN
    localparam int FRAME_BITS = 5;
`else
    localparam int FRAME_BITS = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_i = 1'b1;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic       out_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    serial_code_decoder #(.CLKS_PER_BIT(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (rx_i),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // One expected stop-bit verdict per frame sent
    typedef struct {
        int unsigned cyc;
        logic [1:0]  code;
        bit          par_ok;
        bit          stop_ok;
    } frame_ev_t;

    frame_ev_t   ev_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    bit          rand_rdy = 1'b0;
    bit          rdy_fixed = 1'b0;

    // Model state
    bit         m_valid = 1'b0;
    logic [3:0] m_data = 4'b0000;
    bit         m_perr = 1'b0;
    bit         m_ferr = 1'b0;
    bit         m_ovr = 1'b0;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: applies the verdict of a frame at its stop-sample cycle
    always @(posedge clk) begin : model_p
        bit        load;
        bit        ferr;
        bit        perr;
        bit        ovr;
        frame_ev_t ev;
        load = 1'b0;
        ferr = 1'b0;
        perr = 1'b0;
        ovr  = 1'b0;
        if (rst) begin
            m_valid = 1'b0;
            m_data  = 4'b0000;
            ev_q.delete();
        end else begin
            if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
                ev = ev_q.pop_front();
                if (!ev.stop_ok) ferr = 1'b1;
`ifdef SERIAL_CODE_PARITY_EN
                else if (!ev.par_ok) perr = 1'b1;
`endif
                else if (m_valid && !out_ready) ovr = 1'b1;
                else load = 1'b1;
            end
            if (load) begin
                m_valid = 1'b1;
                m_data  = 4'b0001 << ev.code;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
        m_ferr = ferr;
        m_perr = perr;
        m_ovr  = ovr;
        cyc++;
    end

    // Consumer ready: fixed level or random per cycle
    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? 1'($urandom) : rdy_fixed;
    end

    // Monitor: compare on the falling edge, away from the sampling edge
    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", 4'(out_valid), 4'(m_valid));
            check("frame_err", 4'(frame_err), 4'(m_ferr));
            check("parity_err", 4'(parity_err), 4'(m_perr));
            check("overrun", 4'(overrun), 4'(m_ovr));
            if (m_valid) check("out_data", out_data, m_data);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Send one frame; stop sample lands N/2 + (FRAME_BITS-1)*N cycles after rx_s falls
    task automatic send(input logic [1:0] code, input bit par_ok, input logic stop_val);
        frame_ev_t ev;
        ev.cyc     = cyc + 2 + N / 2 + (FRAME_BITS - 1) * N;
        ev.code    = code;
        ev.par_ok  = par_ok;
        ev.stop_ok = (stop_val == 1'b1);
        ev_q.push_back(ev);
        rx_i = 1'b0;
        tick(N);
        rx_i = code[1];
        tick(N);
        rx_i = code[0];
        tick(N);
`ifdef SERIAL_CODE_PARITY_EN
        rx_i = (code[1] ^ code[0]) ^ !par_ok;
        tick(N);
`endif
        rx_i = stop_val;
        tick(N);
    endtask

    initial begin
        // Reset with idle line
        rst = 1'b1;
        rx_i = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
        check("rst_out_data", out_data, 4'b0000);
        check("rst_out_valid", 4'(out_valid), 4'b0);
        check("rst_parity_err", 4'(parity_err), 4'b0);
        check("rst_frame_err", 4'(frame_err), 4'b0);
        check("rst_overrun", 4'(overrun), 4'b0);
        mon_en = 1'b1;

        // Basic decode with consumer ready
        rdy_fixed = 1'b1;
        tick(2);
        send(2'b10, 1'b1, 1'b1);
        tick(2 * N);

`ifdef SERIAL_CODE_PARITY_EN
        // Bad parity is dropped, following good frame decodes
        send(2'b11, 1'b0, 1'b1);
        send(2'b01, 1'b1, 1'b1);
        tick(2 * N);
`endif

        // Break: stop bit low for three bit times
        send(2'b01, 1'b1, 1'b0);
        tick(2 * N);
        rx_i = 1'b1;
        tick(2 * N);

        // Overrun with consumer stalled, then drain
        rdy_fixed = 1'b0;
        tick(2);
        send(2'b00, 1'b1, 1'b1);
        send(2'b11, 1'b1, 1'b1);
        tick(N);
        rdy_fixed = 1'b1;
        tick(3);

        // One-cycle glitch while idle
        rx_i = 1'b0;
        tick(1);
        rx_i = 1'b1;
        tick(3 * N);

        // Reset mid-frame with a word pending
        rdy_fixed = 1'b0;
        tick(2);
        send(2'b01, 1'b1, 1'b1);
        tick(2);
        rx_i = 1'b0;
        tick(N);
        rx_i = 1'b1;
        tick(N / 2);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("midrst_out_valid", 4'(out_valid), 4'b0);
        check("midrst_out_data", out_data, 4'b0000);
        rdy_fixed = 1'b1;
        tick(2);
        send(2'b11, 1'b1, 1'b1);
        tick(2 * N);

        // Random frames with random consumer back-pressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic [1:0] code;
            bit         par_ok;
            logic       stop_val;
            code     = 2'($urandom);
            par_ok   = ($urandom_range(0, 7) != 0);
            stop_val = ($urandom_range(0, 7) != 0);
            send(code, par_ok, stop_val);
            if (stop_val == 1'b0) begin
                rx_i = 1'b1;
                tick(N);
            end
            tick($urandom_range(0, N));
        end
        rand_rdy  = 1'b0;
        rdy_fixed = 1'b1;
        tick(4 * N);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
